display_scanner: RTL

Time-multiplexed driver for the 4-digit common-anode 7-segment display. It generates the active-low one-hot digit select that the digit multiplexer expects and drives the anodes. It latches the nibble for the current digit, decodes it to active-low segments, and inserts a dead-time between digits to suppress ghosting. It sits between the BCD/hex producers and the board display pins.

---
 rtl/display_scanner_if.sv | 28 ++
 rtl/display_scanner.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/display_scanner_if.sv
// Display scanner bus: digit data in, anode/segment drive out.
// master = data producer side, slave = scanner.
interface display_scanner_if;
  logic       en;
  logic [3:0] dato_D1;
  logic [3:0] dato_D2;
  logic [3:0] dato_D3;
  logic [3:0] dato_D4;
  logic [3:0] dp_in;
  logic       lz_blank;
  logic [3:0] select;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_tick;

  modport master (
    output en, dato_D1, dato_D2, dato_D3, dato_D4,
    output dp_in, lz_blank,
    input  select, an, seg, dp, frame_tick
  );

  modport slave (
    input  en, dato_D1, dato_D2, dato_D3, dato_D4,
    input  dp_in, lz_blank,
    output select, an, seg, dp, frame_tick
  );
endinterface

// File: rtl/display_scanner.sv
// 4-digit common-anode 7-segment scanner with dead-time
// and leading-zero blanking; all outputs registered.
module display_scanner #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int CNT_W        = 16
) (
  input logic             clk,
  input logic             rst_n,
  display_scanner_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] SHOW_LAST =
    CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST =
    CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam bit HAS_BLANK = (BLANK_CYCLES > 0);

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load;

  logic [3:0] nib_q, nib_d;
  logic       dpl_q, dpl_d;
  logic       blk_q, blk_d;

  logic [3:0] sel_q, sel_d;
  logic [6:0] seg_q, seg_d;
  logic       dp_q, dp_d;
  logic       tick_q, tick_d;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Next state, digit index and dwell counter.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    if (!bus.en) begin
      state_d = IDLE;
      idx_d   = 2'd0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = SHOW;
          idx_d   = 2'd0;
          cnt_d   = '0;
          load    = 1'b1;
        end
        SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            cnt_d = '0;
            if (HAS_BLANK) begin
              state_d = BLANK;
            end else begin
              idx_d = idx_q + 2'd1;
              load  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            cnt_d   = '0;
            state_d = SHOW;
            idx_d   = idx_q + 2'd1;
            load    = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = 2'd0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Snapshot of the digit about to be shown, taken on SHOW entry.
  always_comb begin
    nib_d = nib_q;
    dpl_d = dpl_q;
    blk_d = blk_q;
    if (load) begin
      unique case (idx_d)
        2'd0: begin
          nib_d = bus.dato_D1;
          blk_d = 1'b0;
        end
        2'd1: begin
          nib_d = bus.dato_D2;
          blk_d = bus.lz_blank
                & (bus.dato_D4 == 4'd0)
                & (bus.dato_D3 == 4'd0)
                & (bus.dato_D2 == 4'd0);
        end
        2'd2: begin
          nib_d = bus.dato_D3;
          blk_d = bus.lz_blank
                & (bus.dato_D4 == 4'd0)
                & (bus.dato_D3 == 4'd0);
        end
        default: begin
          nib_d = bus.dato_D4;
          blk_d = bus.lz_blank
                & (bus.dato_D4 == 4'd0);
        end
      endcase
      dpl_d = bus.dp_in[idx_d];
    end
  end

  // Output image for the current state; dark unless showing.
  always_comb begin
    sel_d  = 4'hF;
    seg_d  = 7'h7F;
    dp_d   = 1'b1;
    tick_d = 1'b0;
    if (bus.en && state_q == SHOW) begin
      sel_d  = ~(4'b0001 << idx_q);
      seg_d  = blk_q ? 7'h7F : hex7(nib_q);
      dp_d   = ~dpl_q;
      tick_d = (idx_q == 2'd3) && (cnt_q == SHOW_LAST);
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      cnt_q   <= '0;
      nib_q   <= 4'd0;
      dpl_q   <= 1'b0;
      blk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      nib_q   <= nib_d;
      dpl_q   <= dpl_d;
      blk_q   <= blk_d;
    end
  end

  // Output register: anodes and segments switch on one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q  <= 4'hF;
      seg_q  <= 7'h7F;
      dp_q   <= 1'b1;
      tick_q <= 1'b0;
    end else begin
      sel_q  <= sel_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      tick_q <= tick_d;
    end
  end

  assign bus.select     = sel_q;
  assign bus.an         = sel_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.frame_tick = tick_q;

endmodule
